// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer and the ID-stage control decoder.
// Holds the memory-wait FSM encoding, opcode constants and the load-use hazard helper.
package hazard_stall_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int TMO_W       = 8;
    localparam int MEM_TIMEOUT = 200;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2
    } stallState_t;

    // RV32I major opcodes recognised by the control decoder
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    function automatic logic loadUseHazard(
        input logic                  exMemRead,
        input logic [REG_ADDR_W-1:0] exRd,
        input logic [REG_ADDR_W-1:0] idRs1,
        input logic [REG_ADDR_W-1:0] idRs2,
        input logic                  idUseRs2
    );
        logic rdLive;
        rdLive = exMemRead && (exRd != '0);
        return rdLive && ((exRd == idRs1) || (idUseRs2 && (exRd == idRs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: RUN -> WAIT on a miss, WAIT -> RECOVER on ready, with a
// saturating wait timer and a sticky timeout flag.
module mem_wait_fsm
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int TMO_W       = hazard_stall_ctrl_pkg::TMO_W,
    parameter int MEM_TIMEOUT = hazard_stall_ctrl_pkg::MEM_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memMiss,
    input  logic        memReady,
    output stallState_t state,
    output logic        error_o
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    stallState_t      stateNext;
    logic [TMO_W-1:0] timer;
    logic [TMO_W-1:0] timerNext;
    logic [TMO_W-1:0] timerInc;
    logic             errorNext;

    assign timerInc = timer + 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= RUN;
            timer   <= '0;
            error_o <= 1'b0;
        end else begin
            state   <= stateNext;
            timer   <= timerNext;
            error_o <= errorNext;
        end
    end

    always_comb begin
        stateNext = state;
        timerNext = timer;
        errorNext = error_o;
        case (state)
            RUN, RECOVER: begin
                timerNext = '0;
                stateNext = memMiss ? WAIT : RUN;
            end
            WAIT: begin
                if (memReady) begin
                    stateNext = RECOVER;
                    timerNext = '0;
                end else begin
                    // timer parks at the limit so it cannot wrap during a long hang
                    if (timer != TMO_LIMIT) timerNext = timerInc;
                    if (timerInc == TMO_LIMIT) errorNext = 1'b1;
                end
            end
            default: begin
                stateNext = RUN;
                timerNext = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubble, branch flush, memory freeze.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/freeze/flush event counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int TMO_W       = hazard_stall_ctrl_pkg::TMO_W,
    parameter int MEM_TIMEOUT = hazard_stall_ctrl_pkg::MEM_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] ID_rs1_i,
    input  logic [REG_ADDR_W-1:0] ID_rs2_i,
    input  logic                  ID_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] EX_rd_i,
    input  logic                  EX_MemRead_i,
    input  logic                  branch_taken_i,
    input  logic                  MEM_access_i,
    input  logic                  mem_ready_i,
    output logic                  NoOp_o,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  Flush_o,
    output logic                  Freeze_o,
    output logic                  error_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           freeze_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    stallState_t state;
    logic        memMiss;
    logic        loadUse;
    logic        noOp;
    logic        pcWrite;
    logic        ifidWrite;
    logic        flush;
    logic        freeze;

    assign memMiss = MEM_access_i && !mem_ready_i;
    assign loadUse = loadUseHazard(EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i, ID_use_rs2_i);

    mem_wait_fsm #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .memMiss  (memMiss),
        .memReady (mem_ready_i),
        .state    (state),
        .error_o  (error_o)
    );

    // Freeze beats load-use beats flush; a miss freezes in the cycle it is seen so the access stays in MEM
    always_comb begin
        noOp      = 1'b0;
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        flush     = 1'b0;
        freeze    = 1'b0;
        if ((state == WAIT) || memMiss) begin
            freeze    = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
        end else if (loadUse) begin
            noOp      = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
        end else begin
            flush = branch_taken_i;
        end
    end

    assign NoOp_o      = noOp;
    assign PCWrite_o   = pcWrite;
    assign IFIDWrite_o = ifidWrite;
    assign Flush_o     = flush;
    assign Freeze_o    = freeze;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o  <= '0;
            freeze_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (noOp && (stall_cnt_o != 32'hFFFF_FFFF))    stall_cnt_o  <= stall_cnt_o + 32'd1;
            if (freeze && (freeze_cnt_o != 32'hFFFF_FFFF)) freeze_cnt_o <= freeze_cnt_o + 32'd1;
            if (flush && (flush_cnt_o != 32'hFFFF_FFFF))   flush_cnt_o  <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares {NoOp, PCWrite, IFIDWrite, Flush, Freeze, error}.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] ID_rs1_i = '0;
    logic [4:0] ID_rs2_i = '0;
    logic       ID_use_rs2_i = 1'b0;
    logic [4:0] EX_rd_i = '0;
    logic       EX_MemRead_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       MEM_access_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o, error_o;

    hazard_stall_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ID_rs1_i       (ID_rs1_i),
        .ID_rs2_i       (ID_rs2_i),
        .ID_use_rs2_i   (ID_use_rs2_i),
        .EX_rd_i        (EX_rd_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .branch_taken_i (branch_taken_i),
        .MEM_access_i   (MEM_access_i),
        .mem_ready_i    (mem_ready_i),
        .NoOp_o         (NoOp_o),
        .PCWrite_o      (PCWrite_o),
        .IFIDWrite_o    (IFIDWrite_o),
        .Flush_o        (Flush_o),
        .Freeze_o       (Freeze_o),
        .error_o        (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // expected output patterns {NoOp, PCWrite, IFIDWrite, Flush, Freeze, error}
    localparam logic [5:0] E_RUN    = 6'b011000;
    localparam logic [5:0] E_STALL  = 6'b100000;
    localparam logic [5:0] E_FLUSH  = 6'b011100;
    localparam logic [5:0] E_FREEZE = 6'b000010;
    localparam logic [5:0] E_ERR    = 6'b000001;

    always begin
        exp_t       e;
        logic [5:0] got;
        @(negedge clk_i);
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o, error_o};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s: got NoOp/PCW/IFIDW/Flush/Freeze/err=%b required %b at %0t",
                         e.nm, got, e.v, $time);
            end
        end
    end

    task automatic cyc(input logic rstv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic useRs2, input logic [4:0] exRd, input logic exMr,
                       input logic br, input logic ma, input logic mr,
                       input logic [5:0] ev, input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rstv;
        ID_rs1_i       = rs1;
        ID_rs2_i       = rs2;
        ID_use_rs2_i   = useRs2;
        EX_rd_i        = exRd;
        EX_MemRead_i   = exMr;
        branch_taken_i = br;
        MEM_access_i   = ma;
        mem_ready_i    = mr;
        if (nm != "") begin
            e.v  = ev;
            e.nm = nm;
            q.push_back(e);
        end
    endtask

    initial begin
        // reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "reset");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "run_idle");

        // load-use through rs1, then EX holds the bubble
        cyc(1, 5, 0, 0, 5, 1, 0, 0, 0, E_STALL, "lu_rs1");
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "lu_one_bubble");
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, E_RUN,   "lu_rd0");

        // rs2 gating
        cyc(1, 3, 7, 0, 7, 1, 0, 0, 0, E_RUN,   "rs2_unused");
        cyc(1, 3, 7, 1, 7, 1, 0, 0, 0, E_STALL, "rs2_used");
        cyc(1, 3, 7, 1, 7, 0, 0, 0, 0, E_RUN,   "rs2_no_load");

        // branch flush and priority
        cyc(1, 1, 2, 1, 9, 1, 1, 0, 0, E_FLUSH, "br_flush");
        cyc(1, 5, 0, 0, 5, 1, 1, 0, 0, E_STALL, "br_vs_lu");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN,   "mem_hit");

        // memory wait: 4 miss cycles + ready cycle frozen, branch pulses ignored
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, E_FREEZE, "wait_enter");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "wait_1");
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, E_FREEZE, "wait_2_br");
        cyc(1, 5, 0, 0, 5, 1, 0, 1, 0, E_FREEZE, "wait_3_lu");
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, E_FREEZE, "wait_ready");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, E_FLUSH,  "recover_br");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "back_run");

        // new miss straight out of RECOVER, then load-use evaluated in RECOVER
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "miss2_enter");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, E_FREEZE, "miss2_ready");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "recover_miss");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_FREEZE, "wait_held");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, E_FREEZE, "wait_ready2");
        cyc(1, 4, 0, 0, 4, 1, 1, 0, 0, E_STALL,  "recover_lu");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "run_again");

        // timeout: 201 cycles of ready low (RUN miss cycle + 200 WAIT cycles)
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_enter");
        for (int i = 1; i <= 200; i++)
            cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, (i == 200) ? "tmo_edge" : "tmo_wait");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, E_FREEZE | E_ERR, "tmo_err_set");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, E_FLUSH | E_ERR,  "tmo_sticky_rec");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN | E_ERR,    "tmo_sticky_run");

        // async reset in WAIT
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE | E_ERR, "rst_wait_enter");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_FREEZE | E_ERR, "rst_wait_held");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,            "async_rst");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,            "rst_back_run");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, E_FLUSH,          "rst_then_br");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
